match_out_arb: RTL



---
 rtl/match_out_arb_if.sv | 34 +++
 rtl/match_out_arb.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/match_out_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : match_out_arb_if
// Description : Bundles the per-source request side and the serialized match
//               output stream of match_out_arb.
// Revision    : 1.0 - initial release
// ============================================================================
interface match_out_arb_if #(
  parameter int NUM_SRC = 4,
  parameter int DWIDTH  = 512,
  parameter int SRC_W   = $clog2(NUM_SRC)
);
  logic [NUM_SRC-1:0]        in_valid;
  logic [NUM_SRC*DWIDTH-1:0] in_data;
  logic [NUM_SRC-1:0]        in_last;
  logic [NUM_SRC-1:0]        in_ready;
  logic                      out_valid;
  logic [DWIDTH-1:0]         out_data;
  logic                      out_last;
  logic [SRC_W-1:0]          out_src;
  logic                      out_almost_full;

  // Sources and downstream together form the master side.
  modport master (
    output in_valid, in_data, in_last, out_almost_full,
    input  in_ready, out_valid, out_data, out_last, out_src
  );

  modport slave (
    input  in_valid, in_data, in_last, out_almost_full,
    output in_ready, out_valid, out_data, out_last, out_src
  );
endinterface
`default_nettype wire

// File: rtl/match_out_arb.sv
`default_nettype none
// ============================================================================
// Module      : match_out_arb
// Description : Packet-level round-robin arbiter serializing NUM_SRC match
//               engine streams onto one registered output stream.
//               Optional counters enabled by macro MATCH_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module match_out_arb #(
  parameter int NUM_SRC = 4,
  parameter int DWIDTH  = 512,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  wire logic        clk,
  input  wire logic        rst,
  match_out_arb_if.slave   bus,
  output logic             busy
`ifdef MATCH_ARB_STATS_EN
  ,
  output logic [NUM_SRC*32-1:0] stat_msg_cnt,
  output logic [31:0]           stat_stall_cnt
`endif
);

  localparam logic [SRC_W-1:0] c_LAST_SRC = SRC_W'(NUM_SRC - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t             r_state;
  logic [SRC_W-1:0]   r_grant;
  logic [SRC_W-1:0]   r_rr_ptr;
  logic               r_out_valid;
  logic               r_out_last;
  logic [DWIDTH-1:0]  r_out_data;
  logic [SRC_W-1:0]   r_out_src;

  logic               w_any_hi;
  logic               w_any_lo;
  logic [SRC_W-1:0]   w_pick_hi;
  logic [SRC_W-1:0]   w_pick_lo;
  logic               w_any;
  logic [SRC_W-1:0]   w_pick;

  logic               w_grant_valid;
  logic               w_grant_last;
  logic [DWIDTH-1:0]  w_grant_data;
  logic [NUM_SRC-1:0] w_ready;
  logic               w_xfer;

  // Round-robin search split in two: lowest requester at or above the
  // pointer wins, otherwise the lowest requester below it (the wrap).
  always_comb begin
    w_any_hi  = 1'b0;
    w_any_lo  = 1'b0;
    w_pick_hi = '0;
    w_pick_lo = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        if (SRC_W'(i) >= r_rr_ptr) begin
          w_any_hi  = 1'b1;
          w_pick_hi = SRC_W'(i);
        end else begin
          w_any_lo  = 1'b1;
          w_pick_lo = SRC_W'(i);
        end
      end
    end
  end

  assign w_any  = w_any_hi | w_any_lo;
  assign w_pick = w_any_hi ? w_pick_hi : w_pick_lo;

  // Granted-source mux; done as a compare loop so a non power-of-two
  // NUM_SRC never produces an out-of-range select.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_last  = 1'b0;
    w_grant_data  = '0;
    w_ready       = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant == SRC_W'(i)) begin
        w_grant_valid = bus.in_valid[i];
        w_grant_last  = bus.in_last[i];
        w_grant_data  = bus.in_data[i*DWIDTH +: DWIDTH];
        w_ready[i]    = (r_state == ST_SEND) && !bus.out_almost_full;
      end
    end
  end

  assign w_xfer = (r_state == ST_SEND) && w_grant_valid && !bus.out_almost_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Arbitration cycle never moves a beat.
          r_out_valid <= 1'b0;
          if (!bus.out_almost_full && w_any) begin
            r_grant <= w_pick;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_grant_data;
            r_out_last  <= w_grant_last;
            r_out_src   <= r_grant;
            if (w_grant_last) begin
              r_state  <= ST_IDLE;
              r_rr_ptr <= (r_grant == c_LAST_SRC) ? '0 : r_grant + SRC_W'(1);
            end
          end else begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.out_src   = r_out_src;
  assign busy          = (r_state == ST_SEND);

`ifdef MATCH_ARB_STATS_EN
  logic [31:0] r_msg_cnt [NUM_SRC];
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_msg_cnt[i] <= '0;
      end
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_xfer && w_grant_last && (r_grant == SRC_W'(i))) begin
          r_msg_cnt[i] <= r_msg_cnt[i] + 32'd1;
        end
      end
      if ((r_state == ST_SEND) && w_grant_valid && bus.out_almost_full) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_stat_out
      assign stat_msg_cnt[g*32 +: 32] = r_msg_cnt[g];
    end
  endgenerate

  assign stat_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
